// File: rtl/qed_issue_scheduler.sv
// QED issue scheduler: forwards original instructions to the core while buffering them,
// then replays the buffered originals (after external remapping) as duplicates.
module qed_issue_scheduler #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             exec_dup,
    input  logic             ifu_valid_i,
    input  logic [31:0]      ifu_instr_i,
    output logic             ifu_ready_o,
    output logic [31:0]      head_instr_o,
    input  logic [31:0]      qed_instr_i,
    output logic             issue_valid_o,
    output logic [31:0]      issue_instr_o,
    output logic             issue_is_dup_o,
    input  logic             issue_ready_i,
    output logic [CNT_W-1:0] num_orig_o,
    output logic [CNT_W-1:0] num_dup_o,
    output logic             qed_ready_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {ORIG, DUP, DONE} state_t;

    state_t           state, state_next;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, last_entry, slot_free;
    logic             dup_sel, orig_sel;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign last_entry   = ((rd_ptr + PTR_W'(1)) == wr_ptr);
    assign slot_free    = !issue_valid_o || issue_ready_i;
    assign head_instr_o = fifo_empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ORIG;
        end else if (flush_i) begin
            state <= ORIG;
        end else begin
            state <= state_next;
        end
    end

    // Once duplicates start, originals are locked out until flush; the pop that
    // drains the buffer ends the replay.
    always_comb begin
        state_next = state;
        case (state)
            ORIG:    if (dup_sel) state_next = DUP;
            DUP:     if (dup_sel && last_entry) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = ORIG;
        endcase
    end

    always_comb begin
        dup_sel     = 1'b0;
        orig_sel    = 1'b0;
        ifu_ready_o = 1'b0;
        if (!flush_i) begin
            dup_sel  = slot_free && exec_dup && !fifo_empty && (state != DONE);
            orig_sel = (state == ORIG) && slot_free && ifu_valid_i && !fifo_full &&
                       (num_orig_o != {CNT_W{1'b1}}) && !dup_sel;
        end
        ifu_ready_o = orig_sel;
    end

    always_ff @(posedge clk_i) begin
        if (orig_sel) begin
            mem[wr_ptr[AW-1:0]] <= ifu_instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            issue_valid_o  <= 1'b0;
            issue_instr_o  <= 32'h0;
            issue_is_dup_o <= 1'b0;
            num_orig_o     <= '0;
            num_dup_o      <= '0;
            qed_ready_o    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            issue_valid_o  <= 1'b0;
            issue_instr_o  <= 32'h0;
            issue_is_dup_o <= 1'b0;
            num_orig_o     <= '0;
            num_dup_o      <= '0;
            qed_ready_o    <= 1'b0;
        end else begin
            if (dup_sel) begin
                issue_valid_o  <= 1'b1;
                issue_instr_o  <= qed_instr_i;
                issue_is_dup_o <= 1'b1;
                rd_ptr         <= rd_ptr + PTR_W'(1);
                num_dup_o      <= num_dup_o + CNT_W'(1);
            end else if (orig_sel) begin
                issue_valid_o  <= 1'b1;
                issue_instr_o  <= ifu_instr_i;
                issue_is_dup_o <= 1'b0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                num_orig_o     <= num_orig_o + CNT_W'(1);
            end else if (issue_ready_i) begin
                issue_valid_o  <= 1'b0;
            end
            qed_ready_o <= (state == DONE) && (num_orig_o == num_dup_o) &&
                           (num_orig_o != '0) && slot_free;
        end
    end
endmodule

// File: tb/tb_qed_issue_scheduler.sv
// Directed bench for qed_issue_scheduler: a vector table for the basic original/duplicate
// pair plus hand-written sequences for buffering, backpressure, flush and reset.
module tb_qed_issue_scheduler;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam logic [31:0] REMAP = 32'h0000_0F80;
    localparam logic [31:0] IA = 32'h00A0_0093;
    localparam logic [31:0] IB = 32'h0020_8133;
    localparam logic [31:0] IC = 32'h0031_01B3;
    localparam logic [31:0] ID = 32'h0041_8233;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i, exec_dup, ifu_valid_i, ifu_ready_o, issue_ready_i;
    logic [31:0]      ifu_instr_i, head_instr_o, qed_instr_i, issue_instr_o;
    logic             issue_valid_o, issue_is_dup_o, qed_ready_o;
    logic [CNT_W-1:0] num_orig_o, num_dup_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    // Stand-in for the external remapper: flips the rd field of the head entry.
    assign qed_instr_i = head_instr_o ^ REMAP;

    qed_issue_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .exec_dup(exec_dup),
        .ifu_valid_i(ifu_valid_i), .ifu_instr_i(ifu_instr_i), .ifu_ready_o(ifu_ready_o),
        .head_instr_o(head_instr_o), .qed_instr_i(qed_instr_i),
        .issue_valid_o(issue_valid_o), .issue_instr_o(issue_instr_o),
        .issue_is_dup_o(issue_is_dup_o), .issue_ready_i(issue_ready_i),
        .num_orig_o(num_orig_o), .num_dup_o(num_dup_o), .qed_ready_o(qed_ready_o)
    );

    typedef struct {
        logic        flush, dup, valid, rdy;
        logic [31:0] instr;
        logic        exp_ifu_ready, exp_valid, chk_instr, exp_isdup, exp_qr;
        logic [31:0] exp_instr;
        logic [7:0]  exp_orig, exp_dup;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] remap(input logic [31:0] x);
        return x ^ REMAP;
    endfunction

    task automatic applyStimulus(input logic fl, input logic dup, input logic valid,
                                 input logic [31:0] instr, input logic rdy);
        flush_i       = fl;
        exec_dup      = dup;
        ifu_valid_i   = valid;
        ifu_instr_i   = instr;
        issue_ready_i = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic v, input logic chk,
                             input logic [31:0] instr, input logic isdup,
                             input logic [7:0] no, input logic [7:0] nd, input logic qr);
        checkOutput({tag, ".valid"}, 32'(issue_valid_o), 32'(v));
        if (chk) begin
            checkOutput({tag, ".instr"}, issue_instr_o, instr);
            checkOutput({tag, ".is_dup"}, 32'(issue_is_dup_o), 32'(isdup));
        end
        checkOutput({tag, ".num_orig"}, 32'(num_orig_o), 32'(no));
        checkOutput({tag, ".num_dup"}, 32'(num_dup_o), 32'(nd));
        checkOutput({tag, ".qed_ready"}, 32'(qed_ready_o), 32'(qr));
    endtask

    task automatic doFlush;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
    endtask

    initial begin
        //          fl   dup  val  rdy  instr  ifu_rdy valid chk  isdup qr   exp_instr   orig dup
        vecs[0] = '{1'b0,1'b0,1'b1,1'b1,IA,    1'b1,  1'b1, 1'b1,1'b0, 1'b0,IA,         8'd1,8'd0};
        vecs[1] = '{1'b0,1'b0,1'b1,1'b1,IB,    1'b1,  1'b1, 1'b1,1'b0, 1'b0,IB,         8'd2,8'd0};
        vecs[2] = '{1'b0,1'b1,1'b0,1'b1,32'h0, 1'b0,  1'b1, 1'b1,1'b1, 1'b0,remap(IA),  8'd2,8'd1};
        vecs[3] = '{1'b0,1'b1,1'b0,1'b1,32'h0, 1'b0,  1'b1, 1'b1,1'b1, 1'b0,remap(IB),  8'd2,8'd2};
        vecs[4] = '{1'b0,1'b1,1'b0,1'b1,32'h0, 1'b0,  1'b0, 1'b0,1'b0, 1'b1,32'h0,      8'd2,8'd2};
        vecs[5] = '{1'b0,1'b0,1'b1,1'b1,IA,    1'b0,  1'b0, 1'b0,1'b0, 1'b1,32'h0,      8'd2,8'd2};

        rst_ni = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        checkRegs("reset", 1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("reset.head", head_instr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        $display("[TB] basic pair");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].flush, vecs[i].dup, vecs[i].valid, vecs[i].instr, vecs[i].rdy);
            checkOutput($sformatf("vec%0d.ifu_ready", i), 32'(ifu_ready_o), 32'(vecs[i].exp_ifu_ready));
            tick();
            checkRegs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_instr,
                      vecs[i].exp_instr, vecs[i].exp_isdup, vecs[i].exp_orig,
                      vecs[i].exp_dup, vecs[i].exp_qr);
        end

        $display("[TB] full buffer, two runs");
        for (int run = 0; run < 2; run++) begin
            logic [31:0] base;
            base = (run == 0) ? 32'h0000_0100 : 32'h0000_0300;
            doFlush();
            checkRegs("flush_full", 1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 8'd0, 1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(1'b0, 1'b0, 1'b1, base + 32'(i), 1'b1);
                checkOutput($sformatf("fill%0d.ifu_ready", i), 32'(ifu_ready_o), 32'd1);
                tick();
            end
            applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_0000, 1'b1);
            checkOutput("full.ifu_ready", 32'(ifu_ready_o), 32'd0);
            tick();
            checkRegs("full", 1'b0, 1'b0, 32'h0, 1'b0, 8'd16, 8'd0, 1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
                checkOutput($sformatf("drain%0d.head", i), head_instr_o, base + 32'(i));
                tick();
                checkOutput($sformatf("drain%0d.instr", i), issue_instr_o, remap(base + 32'(i)));
                checkOutput($sformatf("drain%0d.is_dup", i), 32'(issue_is_dup_o), 32'd1);
            end
            applyStimulus(1'b0, 1'b1, 1'b1, 32'hBEEF_0000, 1'b1);
            checkOutput("done.ifu_ready", 32'(ifu_ready_o), 32'd0);
            checkOutput("done.head", head_instr_o, 32'h0);
            tick();
            checkRegs("done", 1'b0, 1'b0, 32'h0, 1'b0, 8'd16, 8'd16, 1'b1);
        end

        $display("[TB] empty dup request");
        doFlush();
        applyStimulus(1'b0, 1'b1, 1'b1, IC, 1'b1);
        checkOutput("empty_dup.ifu_ready", 32'(ifu_ready_o), 32'd1);
        tick();
        checkRegs("empty_dup0", 1'b1, 1'b1, IC, 1'b0, 8'd1, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, ID, 1'b1);
        checkOutput("empty_dup1.ifu_ready", 32'(ifu_ready_o), 32'd0);
        tick();
        checkRegs("empty_dup1", 1'b1, 1'b1, remap(IC), 1'b1, 8'd1, 8'd1, 1'b0);

        $display("[TB] sticky dup");
        doFlush();
        applyStimulus(1'b0, 1'b0, 1'b1, IA, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IB, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IC, 1'b1); tick();
        applyStimulus(1'b0, 1'b1, 1'b1, ID, 1'b1);
        checkOutput("sticky.first_ifu_ready", 32'(ifu_ready_o), 32'd0);
        tick();
        checkRegs("sticky.first", 1'b1, 1'b1, remap(IA), 1'b1, 8'd3, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, ID, 1'b1);
            checkOutput($sformatf("sticky.idle%0d.ifu_ready", i), 32'(ifu_ready_o), 32'd0);
            tick();
        end
        checkRegs("sticky.idle", 1'b0, 1'b0, 32'h0, 1'b0, 8'd3, 8'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, ID, 1'b1);
        checkOutput("sticky.dup2.head", head_instr_o, IB);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, ID, 1'b1);
        checkOutput("sticky.dup3.ifu_ready", 32'(ifu_ready_o), 32'd0);
        tick();
        checkRegs("sticky.dup3", 1'b1, 1'b1, remap(IC), 1'b1, 8'd3, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, ID, 1'b1);
        checkOutput("sticky.done.ifu_ready", 32'(ifu_ready_o), 32'd0);
        tick();
        checkRegs("sticky.done", 1'b0, 1'b0, 32'h0, 1'b0, 8'd3, 8'd3, 1'b1);

        $display("[TB] backpressure then flush");
        doFlush();
        applyStimulus(1'b0, 1'b0, 1'b1, IA, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IB, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IC, 1'b1); tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i % 2) == 1, 1'b1, ID, 1'b0);
            checkOutput($sformatf("bp%0d.ifu_ready", i), 32'(ifu_ready_o), 32'd0);
            tick();
            checkRegs($sformatf("bp%0d", i), 1'b1, 1'b1, IC, 1'b0, 8'd3, 8'd0, 1'b0);
            checkOutput($sformatf("bp%0d.head", i), head_instr_o, IA);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, ID, 1'b0);
        tick();
        checkRegs("flush_mid", 1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("flush_mid.head", head_instr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, ID, 1'b1);
        checkOutput("flush_mid.orig_state", 32'(ifu_ready_o), 32'd1);
        tick();
        checkRegs("after_flush", 1'b1, 1'b1, ID, 1'b0, 8'd1, 8'd0, 1'b0);

        $display("[TB] async reset mid-stream");
        doFlush();
        applyStimulus(1'b0, 1'b0, 1'b1, IA, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IB, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IC, 1'b1); tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        rst_ni = 1'b0;
        #1;
        checkRegs("rst_mid", 1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("rst_mid.head", head_instr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, IB, 1'b1);
        checkOutput("after_rst.ifu_ready", 32'(ifu_ready_o), 32'd1);
        tick();
        checkRegs("after_rst", 1'b1, 1'b1, IB, 1'b0, 8'd1, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
